// File: rtl/dec_pkg.sv
// Shared definitions for the dec_scan select-bus decoder.
//   state_t     : controller states (off, direct decode, autonomous scan)
//   MODE_DIRECT : mode input value selecting direct decode
//   MODE_SCAN   : mode input value selecting scan
package dec_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index to one-hot decoder with a range-valid flag.
//   sel    : index to decode
//   onehot : NUM_OUT-wide one-hot of sel, all zeros when sel >= NUM_OUT
//   valid  : high when sel < NUM_OUT
module onehot_dec #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_OUT = 8
) (
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] onehot,
    output logic               valid
);

    // Compare against every used position; unused codes decode to nothing.
    always_comb begin
        onehot = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (sel == SEL_W'(i)) begin
                onehot[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec_scan.sv
// Registered N-to-2^N one-hot select decoder with enable, range checking
// and an autonomous scan mode with programmable dwell.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : block enable; low forces all outputs low
//   mode       : MODE_DIRECT decodes in, MODE_SCAN walks the active bit
//   load       : scan only; restarts the scan at in
//   in         : direct index or scan load value
//   out        : registered one-hot select
//   idx        : index currently driven on out
//   wrap       : one-cycle pulse as the scan steps from NUM_OUT-1 to 0
//   range_err  : registered flag for an out-of-range in that was used
module dec_scan
    import dec_pkg::*;
#(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_OUT = 8,
    parameter int unsigned DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               load,
    input  logic [SEL_W-1:0]   in,
    output logic [NUM_OUT-1:0] out,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap,
    output logic               range_err
);

    localparam int unsigned      CNT_W      = $clog2(DWELL + 1);
    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_OUT - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t             state;
    logic [CNT_W-1:0]   dwell_cnt;

    logic               in_ok_c;
    logic               step_c;
    logic [SEL_W-1:0]   step_idx_c;
    logic [SEL_W-1:0]   dec_sel_c;
    logic [NUM_OUT-1:0] dec_onehot_c;
    logic               dec_valid_c;

    // Pick the index that out will show after this edge. A scan that is
    // just being entered holds its current idx, so only a running scan steps.
    always_comb begin
        in_ok_c    = ({1'b0, in} < (SEL_W + 1)'(NUM_OUT));
        step_c     = (state == ST_SCAN) && (dwell_cnt == DWELL_LAST);
        step_idx_c = (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
        dec_sel_c  = idx;
        if ((mode == MODE_DIRECT) || (load && in_ok_c)) begin
            dec_sel_c = in;
        end else if (step_c) begin
            dec_sel_c = step_idx_c;
        end
    end

    onehot_dec #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .sel    (dec_sel_c),
        .onehot (dec_onehot_c),
        .valid  (dec_valid_c)
    );

    // Controller: state, index, dwell counter and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            idx       <= '0;
            dwell_cnt <= '0;
            out       <= '0;
            wrap      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            wrap      <= 1'b0;
            range_err <= 1'b0;
            if (!en) begin
                state <= ST_OFF;
                out   <= '0;
            end else if (mode == MODE_DIRECT) begin
                state     <= ST_DIRECT;
                dwell_cnt <= '0;
                out       <= dec_onehot_c;
                range_err <= !dec_valid_c;
                if (dec_valid_c) begin
                    idx <= in;
                end
            end else begin
                state     <= ST_SCAN;
                out       <= dec_onehot_c;
                range_err <= load && !in_ok_c;
                // A rejected load leaves the scan running as if load were low.
                if (load && in_ok_c) begin
                    idx       <= in;
                    dwell_cnt <= '0;
                end else if (state != ST_SCAN) begin
                    dwell_cnt <= '0;
                end else if (step_c) begin
                    idx       <= step_idx_c;
                    dwell_cnt <= '0;
                    wrap      <= (idx == LAST_IDX);
                end else begin
                    dwell_cnt <= dwell_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dec_scan.sv
// Self-checking bench for dec_scan: two instances (8 outputs / dwell 4 and
// 6 outputs / dwell 1) share stimulus; a reference model pushes expected
// outputs per driven cycle and a monitor pops and compares them, while each
// test task also checks the scenario's specific values inline.
module tb_dec_scan;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned N_A   = 8;
    localparam int unsigned DW_A  = 4;
    localparam int unsigned N_B   = 6;
    localparam int unsigned DW_B  = 1;

    typedef struct packed {
        logic [7:0] out;
        logic [2:0] idx;
        logic       wrap;
        logic       err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] in;

    logic [N_A-1:0]   out_a;
    logic [SEL_W-1:0] idx_a;
    logic             wrap_a;
    logic             err_a;
    logic [N_B-1:0]   out_b;
    logic [SEL_W-1:0] idx_b;
    logic             wrap_b;
    logic             err_b;

    int errors = 0;
    int checks = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a;
    exp_t mon_b;

    int unsigned m_idx[2];
    int unsigned m_left[2];
    bit          m_scan[2];

    always #5 clk = ~clk;

    dec_scan #(.SEL_W(SEL_W), .NUM_OUT(N_A), .DWELL(DW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .in(in),
        .out(out_a), .idx(idx_a), .wrap(wrap_a), .range_err(err_a)
    );

    dec_scan #(.SEL_W(SEL_W), .NUM_OUT(N_B), .DWELL(DW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .in(in),
        .out(out_b), .idx(idx_b), .wrap(wrap_b), .range_err(err_b)
    );

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_idx[d]  = 0;
            m_left[d] = 0;
            m_scan[d] = 1'b0;
        end
    endtask

    // Reference behaviour: m_left counts the cycles still to show m_idx.
    task automatic model_step(input int d, input logic e, input logic m,
                              input logic l, input logic [2:0] i, output exp_t x);
        int unsigned n;
        int unsigned dw;
        int unsigned iv;
        n  = (d == 0) ? N_A : N_B;
        dw = (d == 0) ? DW_A : DW_B;
        iv = 32'(i);
        x  = '0;
        if (!e) begin
            m_scan[d] = 1'b0;
        end else if (!m) begin
            m_scan[d] = 1'b0;
            if (iv < n) begin
                m_idx[d] = iv;
                x.out    = 8'(1) << iv;
            end else begin
                x.err = 1'b1;
            end
        end else begin
            if (l && iv < n) begin
                m_idx[d]  = iv;
                m_left[d] = dw;
            end else begin
                x.err = l;
                if (!m_scan[d]) begin
                    m_left[d] = dw;
                end else if (m_left[d] == 1) begin
                    x.wrap    = (m_idx[d] == n - 1);
                    m_idx[d]  = (m_idx[d] == n - 1) ? 0 : m_idx[d] + 1;
                    m_left[d] = dw;
                end else begin
                    m_left[d] = m_left[d] - 1;
                end
            end
            m_scan[d] = 1'b1;
            x.out     = 8'(1) << m_idx[d];
        end
        x.idx = 3'(m_idx[d]);
    endtask

    // Drive one cycle of stimulus, queue the expectations, return after the edge.
    task automatic step(input logic e, input logic m, input logic l, input logic [2:0] i);
        exp_t x;
        @(negedge clk);
        en   = e;
        mode = m;
        load = l;
        in   = i;
        model_step(0, e, m, l, i, x);
        q_a.push_back(x);
        model_step(1, e, m, l, i, x);
        q_b.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: compare every queued expectation after its edge.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            mon_a = q_a.pop_front();
            checks++;
            if ({out_a, idx_a, wrap_a, err_a} !== mon_a) begin
                errors++;
                $display("FAIL sb_a: out=%b idx=%0d wrap=%b err=%b, expected out=%b idx=%0d wrap=%b err=%b",
                         out_a, idx_a, wrap_a, err_a, mon_a.out, mon_a.idx, mon_a.wrap, mon_a.err);
            end
        end
        if (q_b.size() > 0) begin
            mon_b = q_b.pop_front();
            checks++;
            if ({2'b00, out_b, idx_b, wrap_b, err_b} !== mon_b) begin
                errors++;
                $display("FAIL sb_b: out=%b idx=%0d wrap=%b err=%b, expected out=%b idx=%0d wrap=%b err=%b",
                         out_b, idx_b, wrap_b, err_b, mon_b.out[5:0], mon_b.idx, mon_b.wrap, mon_b.err);
            end
        end
    end

    task automatic test_reset();
        reset_model();
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 1'b0;
        load  = 1'b0;
        in    = 3'd5;
        #1;
        checks++;
        if ({out_a, idx_a, wrap_a, err_a} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: out=%b idx=%0d wrap=%b err=%b, expected all zero",
                     out_a, idx_a, wrap_a, err_a);
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: out=%b before first edge, expected 0", out_a);
        end
        step(1'b1, 1'b0, 1'b0, 3'd5);
        checks++;
        if (out_a !== 8'b0010_0000 || idx_a !== 3'd5) begin
            errors++;
            $display("FAIL reset_first_edge: out=%b idx=%0d, expected 00100000 idx=5", out_a, idx_a);
        end
    endtask

    task automatic test_direct_sweep();
        logic [5:0] eo;
        logic [2:0] ei;
        logic       ee;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b0, 3'(k));
            if (k < 6) begin
                eo = 6'(1) << k;
                ei = 3'(k);
                ee = 1'b0;
            end else begin
                eo = 6'd0;
                ei = 3'd5;
                ee = 1'b1;
            end
            checks++;
            if (out_b !== eo || idx_b !== ei || err_b !== ee) begin
                errors++;
                $display("FAIL direct_sweep in=%0d: out=%b idx=%0d err=%b, expected out=%b idx=%0d err=%b",
                         k, out_b, idx_b, err_b, eo, ei, ee);
            end
        end
    endtask

    task automatic test_scan_wrap();
        int wraps;
        int wrap_at;
        logic [7:0] eo;
        wraps   = 0;
        wrap_at = -1;
        step(1'b1, 1'b0, 1'b0, 3'd0);
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0);
            eo = 8'(1) << ((c / 4) % 8);
            checks++;
            if ($countones(out_a) != 1 || out_a !== eo) begin
                errors++;
                $display("FAIL scan_pos cycle=%0d: out=%b, expected %b", c, out_a, eo);
            end
            if (wrap_a === 1'b1) begin
                wraps++;
                wrap_at = c;
            end
        end
        checks++;
        if (wraps != 1 || wrap_at != 32) begin
            errors++;
            $display("FAIL scan_wrap: wraps=%0d at cycle %0d, expected 1 at cycle 32", wraps, wrap_at);
        end
    endtask

    task automatic test_load();
        step(1'b1, 1'b0, 1'b0, 3'd6);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd3);
        checks++;
        if (out_a !== 8'b0000_1000 || idx_a !== 3'd3) begin
            errors++;
            $display("FAIL load_apply: out=%b idx=%0d, expected 00001000 idx=3", out_a, idx_a);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0);
            checks++;
            if (out_a !== 8'b0000_1000) begin
                errors++;
                $display("FAIL load_hold k=%0d: out=%b, expected 00001000", k, out_a);
            end
        end
        step(1'b1, 1'b1, 1'b0, 3'd0);
        checks++;
        if (out_a !== 8'b0001_0000 || idx_a !== 3'd4) begin
            errors++;
            $display("FAIL load_advance: out=%b idx=%0d, expected 00010000 idx=4", out_a, idx_a);
        end
    endtask

    task automatic test_enable_drop();
        step(1'b1, 1'b0, 1'b0, 3'd2);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0, 3'd0);
            checks++;
            if (out_a !== 8'd0 || idx_a !== 3'd2) begin
                errors++;
                $display("FAIL en_low k=%0d: out=%b idx=%0d, expected 0 idx=2", k, out_a, idx_a);
            end
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0);
            checks++;
            if (out_a !== 8'b0000_0100) begin
                errors++;
                $display("FAIL en_resume k=%0d: out=%b, expected 00000100", k, out_a);
            end
        end
        step(1'b1, 1'b1, 1'b0, 3'd0);
        checks++;
        if (out_a !== 8'b0000_1000) begin
            errors++;
            $display("FAIL en_resume_step: out=%b, expected 00001000", out_a);
        end
    endtask

    task automatic test_range_load();
        step(1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd6);
        checks++;
        if (err_b !== 1'b1 || err_a !== 1'b0 || out_a !== 8'b0100_0000) begin
            errors++;
            $display("FAIL range_load: err_b=%b err_a=%b out_a=%b, expected 1 0 01000000",
                     err_b, err_a, out_a);
        end
        step(1'b1, 1'b1, 1'b0, 3'd0);
        checks++;
        if (err_b !== 1'b0) begin
            errors++;
            $display("FAIL range_load_clear: err_b=%b, expected 0", err_b);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 3'd6);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        #1;
        rst_n = 1'b0;
        reset_model();
        #1;
        checks++;
        if (out_a !== 8'd0 || idx_a !== 3'd0 || wrap_a !== 1'b0 || out_b !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: out=%b idx=%0d wrap=%b out_b=%b, expected all zero",
                     out_a, idx_a, wrap_a, out_b);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0);
            checks++;
            if (out_a !== 8'b0000_0001 || idx_a !== 3'd0) begin
                errors++;
                $display("FAIL restart k=%0d: out=%b idx=%0d, expected 00000001 idx=0", k, out_a, idx_a);
            end
        end
        step(1'b1, 1'b1, 1'b0, 3'd0);
        checks++;
        if (out_a !== 8'b0000_0010) begin
            errors++;
            $display("FAIL restart_step: out=%b, expected 00000010", out_a);
        end
    endtask

    initial begin
        test_reset();
        test_direct_sweep();
        test_scan_wrap();
        test_load();
        test_enable_drop();
        test_range_load();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec_scan.md
# dec_scan

Registered, parametrised N-to-2^N one-hot decoder with enable, range checking and an autonomous scan mode. It drives one-hot select lines such as display digit enables, LED banks and chip selects. In direct mode it decodes a supplied index; in scan mode it walks the active output through all positions with a programmable dwell time. It replaces ad-hoc combinational decoders wherever a glitch-free, latch-free registered select bus is required.

## Interface
- SEL_W, 3: index width.
- NUM_OUT, 8: number of outputs used; 2 ≤ NUM_OUT ≤ 2**SEL_W.
- DWELL, 4: cycles each position is held in scan mode; DWELL ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; when 0, all outputs go low.
- mode  in  1  0 = direct decode, 1 = scan.
- load  in  1  scan mode only: sets the index to `in` and restarts the dwell.
- in  in  SEL_W  direct-mode index, or scan load value.
- out  out  NUM_OUT  registered one-hot select; all zeros when inactive.
- idx  out  SEL_W  index currently driven on `out`.
- wrap  out  1  one-cycle pulse when the scan steps from NUM_OUT-1 to 0.
- range_err  out  1  registered; high while `in` ≥ NUM_OUT in a cycle where `in` is used.

## Operation
- States: OFF, DIRECT, SCAN. The next state is decided each edge:
  - en=0 → OFF.
  - en=1, mode=0 → DIRECT.
  - en=1, mode=1 → SCAN.
- OFF:
  - out=0, wrap=0, range_err=0.
  - idx and the dwell count hold their values.
- DIRECT:
  - If `in` < NUM_OUT: idx←in and out←1<<in.
  - If `in` ≥ NUM_OUT: out←0, range_err←1, idx holds.
  - The dwell count is cleared.
- SCAN:
  - out is always 1<<idx.
  - The dwell counter counts 0..DWELL-1. When it reaches DWELL-1, idx advances and the counter returns to 0.
  - idx advances as idx+1, or to 0 when idx=NUM_OUT-1; wrap is asserted on that edge.
  - load=1 has priority over advancing: idx←in and the dwell count←0. If `in` ≥ NUM_OUT, the load is ignored and range_err←1 for that cycle.
- Priority: en=0 > load > dwell advance.
- Entering SCAN from DIRECT or OFF:
  - Scanning starts at the current idx with the dwell count at 0.
  - The first position is held for the full DWELL cycles.
- Width rules:
  - idx arithmetic is SEL_W bits wide; the wrap point is NUM_OUT-1, not 2**SEL_W-1.
  - The dwell counter is $clog2(DWELL+1) bits wide.
- Reset (asynchronous, any time, including mid-scan):
  - out=0, idx=0, wrap=0, range_err=0.
  - Dwell count=0, state=OFF.
  - After release, the first edge follows the normal rules.

## Timing
- All outputs come from registers; there are no combinational paths from inputs to outputs.
- DIRECT latency is 1 cycle: `in` sampled at edge k appears on out after edge k.
- SCAN: each index is held exactly DWELL cycles. One full period is NUM_OUT×DWELL cycles.
- wrap is high for exactly one cycle, coincident with out becoming bit 0.
- en falling: out is zero after the next edge. en rising in SCAN: out=1<<idx after the next edge.
- load: the new index appears on out after the loading edge and is held for DWELL cycles.
- DWELL=1: idx advances every cycle.

## Structure
- Shared package dec_pkg holds:
  - state encoding: ST_OFF, ST_DIRECT, ST_SCAN.
  - mode constants: MODE_DIRECT=0, MODE_SCAN=1.
- Sub-module onehot_dec (parameters SEL_W, NUM_OUT):
  - purely combinational index → one-hot, plus a range-valid flag.
  - instantiated once, ahead of the output register.
- The top level contains the state register, idx register, dwell counter and output registers.

## Test plan
- Reset with en=1, mode=0, in=5 → after release, out=0 until the first edge, then out=8'b0010_0000, idx=5.
- Direct sweep in=0..7 with NUM_OUT=6 → out=1<<in for 0..5; in=6,7 give out=0, range_err=1, idx holding at 5.
- Scan with DWELL=4, NUM_OUT=8, starting idx=0 → each bit is held 4 cycles. wrap pulses once when 7→0, at cycle 32 after entry; exactly one out bit is ever high.
- Scan with load in=3 mid-dwell at idx=6 → out=8'b0000_1000 next cycle, held 4 cycles, then idx=4.
- en dropped mid-scan at idx=2 for 10 cycles → out=0, idx stays 2. On re-enable, out=8'b0000_0100 for a full 4 cycles.
- rst_n asserted asynchronously mid-dwell at idx=6 → out, idx, wrap clear immediately without a clock; the scan restarts from idx 0.
